// File: rtl/perf_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : perf_run_monitor
// Purpose  : Run-control and performance monitor for the rv32_x core.
//            Provides a saturating cycle counter, NUM_EVT saturating event
//            counters, a watchdog that trips TIMEOUT RUN cycles after RUN
//            entry, and end-of-test detection from a store to TOHOST_ADDR.
//            Counters and a status word are read through a one-cycle-latency
//            read port.
// Ports    : clk, rst_n (sync active-low)
//            start_i / stop_i          run control
//            evt_i[NUM_EVT]            event strobes, counted only in RUN
//            st_valid_i/st_addr_i/st_data_i  core store snoop
//            rd_en_i / rd_idx_i        read request (0=cycle, 1..NUM_EVT=evt,
//                                      NUM_EVT+1=status, others read 0)
//            rd_data_o / rd_valid_o    read response, one cycle later
//            running_o/done_o/pass_o/timeout_o  status outputs
//            snap_i                    snapshot strobe (optional build)
// Config   : PERF_RUN_MONITOR_SNAPSHOT_EN adds snap_i and a shadow copy of
//            all counters; counter reads then return the shadow.
// Revision : 1.0  initial release
// ============================================================================
module perf_run_monitor #(
    parameter int          CNT_W       = 32,
    parameter int          NUM_EVT     = 4,
    parameter int          TIMEOUT     = 10000,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter int          IDX_W       = $clog2(NUM_EVT + 2)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               st_valid_i,
    input  logic [31:0]        st_addr_i,
    input  logic [31:0]        st_data_i,
`ifdef PERF_RUN_MONITOR_SNAPSHOT_EN
    input  logic               snap_i,
`endif
    input  logic               rd_en_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_valid_o,
    output logic               running_o,
    output logic               done_o,
    output logic               pass_o,
    output logic               timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } state_t;

    localparam int              c_num_cnt  = NUM_EVT + 1;  // cycle + events
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_near = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT - 1);
    // A narrow cycle counter may saturate before TIMEOUT-1; the watchdog
    // must then never fire rather than match a truncated limit.
    localparam bit c_tmo_reach = (CNT_W >= 31) ? 1'b1 : ((TIMEOUT - 1) < (2 ** CNT_W));

    if (NUM_EVT < 1 || NUM_EVT > 16) begin : g_chk_num_evt
        $error("perf_run_monitor: NUM_EVT must be in 1..16");
    end
    if (NUM_EVT + 4 > CNT_W) begin : g_chk_status_width
        $error("perf_run_monitor: NUM_EVT+4 must not exceed CNT_W");
    end
    if (TIMEOUT < 2) begin : g_chk_timeout
        $error("perf_run_monitor: TIMEOUT must be >= 2");
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_pass;
    logic                   w_pass_nxt;
    logic                   w_clear;
    logic                   w_count;
    logic                   w_tohost;
    logic                   w_tmo_hit;
    // Index 0 is the cycle counter, index k+1 is event counter k.
    logic [CNT_W-1:0]       r_cnt [c_num_cnt];
    logic [c_num_cnt-1:0]   r_ovf;
    logic [c_num_cnt-1:0]   w_inc;
    logic [CNT_W-1:0]       w_src [c_num_cnt];
    logic [CNT_W-1:0]       w_status;
    logic [CNT_W-1:0]       w_rd_mux;
    logic [CNT_W-1:0]       r_rd_data;
    logic                   r_rd_valid;

    assign w_inc     = {evt_i, 1'b1};
    assign w_tohost  = st_valid_i && (st_addr_i == TOHOST_ADDR);
    assign w_tmo_hit = c_tmo_reach && (r_cnt[0] == c_tmo_last);

    // Next-state: start_i wins everywhere; in RUN a tohost store beats the
    // watchdog, which beats stop_i. DONE/TMO only leave through start_i.
    always_comb begin
        w_state_nxt = r_state;
        w_pass_nxt  = r_pass;
        w_clear     = 1'b0;
        w_count     = 1'b0;
        if (start_i) begin
            w_state_nxt = ST_RUN;
            w_pass_nxt  = 1'b0;
            w_clear     = 1'b1;
        end else if (r_state == ST_RUN) begin
            w_count = 1'b1;
            if (w_tohost) begin
                w_state_nxt = ST_DONE;
                w_pass_nxt  = (st_data_i == 32'h1);
            end else if (w_tmo_hit) begin
                w_state_nxt = ST_TMO;
            end else if (stop_i) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pass  <= 1'b0;
            r_ovf   <= '0;
            for (int i = 0; i < c_num_cnt; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pass  <= w_pass_nxt;
            if (w_clear) begin
                r_ovf <= '0;
                for (int i = 0; i < c_num_cnt; i++) begin
                    r_cnt[i] <= '0;
                end
            end else if (w_count) begin
                for (int i = 0; i < c_num_cnt; i++) begin
                    if (w_inc[i] && (r_cnt[i] != c_cnt_max)) begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        if (r_cnt[i] == c_cnt_near) begin
                            r_ovf[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef PERF_RUN_MONITOR_SNAPSHOT_EN
    // Shadow survives start_i so a snapshot can be read after a restart.
    logic [CNT_W-1:0] r_shd [c_num_cnt];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_num_cnt; i++) begin
                r_shd[i] <= '0;
            end
        end else if (snap_i) begin
            for (int i = 0; i < c_num_cnt; i++) begin
                r_shd[i] <= r_cnt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < c_num_cnt; i++) begin
            w_src[i] = r_shd[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < c_num_cnt; i++) begin
            w_src[i] = r_cnt[i];
        end
    end
`endif

    always_comb begin
        w_status                    = '0;
        w_status[1:0]               = r_state;
        w_status[2]                 = r_pass;
        w_status[3 +: NUM_EVT + 1]  = r_ovf;
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < c_num_cnt; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                w_rd_mux = w_src[i];
            end
        end
        if (rd_idx_i == IDX_W'(NUM_EVT + 1)) begin
            w_rd_mux = w_status;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en_i;
            if (rd_en_i) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;
    assign running_o  = (r_state == ST_RUN);
    assign done_o     = (r_state == ST_DONE);
    assign timeout_o  = (r_state == ST_TMO);
    assign pass_o     = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_perf_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_run_monitor
// Purpose  : Directed self-checking bench for perf_run_monitor. A 32-bit
//            instance (TIMEOUT=200) covers pass/timeout/priority/reset/read
//            behaviour; an 8-bit instance covers saturation and overflow.
// Revision : 1.0  initial release
// ============================================================================
module tb_perf_run_monitor;

    localparam int          TMO    = 200;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Main instance stimulus / observation
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [3:0]  evt = '0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0, st_data = '0;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_idx = '0;
    logic [31:0] rd_data;
    logic        rd_valid, running, done, pass, timeout;
`ifdef PERF_RUN_MONITOR_SNAPSHOT_EN
    logic        snap = 1'b0;
    logic        s_snap = 1'b0;
`endif

    // Saturation instance
    logic        s_start = 1'b0, s_stop = 1'b0;
    logic [3:0]  s_evt = '0;
    logic        s_st_valid = 1'b0;
    logic [31:0] s_st_addr = '0, s_st_data = '0;
    logic        s_rd_en = 1'b0;
    logic [2:0]  s_rd_idx = '0;
    logic [7:0]  s_rd_data;
    logic        s_rd_valid, s_running, s_done, s_pass, s_timeout;

    perf_run_monitor #(
        .CNT_W(32), .NUM_EVT(4), .TIMEOUT(TMO), .TOHOST_ADDR(TOHOST)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .evt_i(evt),
        .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data),
`ifdef PERF_RUN_MONITOR_SNAPSHOT_EN
        .snap_i(snap),
`endif
        .rd_en_i(rd_en), .rd_idx_i(rd_idx), .rd_data_o(rd_data),
        .rd_valid_o(rd_valid), .running_o(running), .done_o(done),
        .pass_o(pass), .timeout_o(timeout)
    );

    perf_run_monitor #(
        .CNT_W(8), .NUM_EVT(4), .TIMEOUT(1000), .TOHOST_ADDR(TOHOST)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .stop_i(s_stop), .evt_i(s_evt),
        .st_valid_i(s_st_valid), .st_addr_i(s_st_addr), .st_data_i(s_st_data),
`ifdef PERF_RUN_MONITOR_SNAPSHOT_EN
        .snap_i(s_snap),
`endif
        .rd_en_i(s_rd_en), .rd_idx_i(s_rd_idx), .rd_data_o(s_rd_data),
        .rd_valid_o(s_rd_valid), .running_o(s_running), .done_o(s_done),
        .pass_o(s_pass), .timeout_o(s_timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 ns later.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_main(input string tag, input logic [2:0] idx, input logic [63:0] exp);
        rd_en  = 1'b1;
        rd_idx = idx;
        step(1);
        rd_en  = 1'b0;
        check({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check(tag, 64'(rd_data), exp);
    endtask

    task automatic rd_sat(input string tag, input logic [2:0] idx, input logic [63:0] exp);
        s_rd_en  = 1'b1;
        s_rd_idx = idx;
        step(1);
        s_rd_en  = 1'b0;
        check({tag, "_valid"}, 64'(s_rd_valid), 64'd1);
        check(tag, 64'(s_rd_data), exp);
    endtask

    task automatic check_flags(input string tag, input logic r, input logic d,
                               input logic p, input logic t);
        check({tag, "_running"}, 64'(running), 64'(r));
        check({tag, "_done"},    64'(done),    64'(d));
        check({tag, "_pass"},    64'(pass),    64'(p));
        check({tag, "_timeout"}, 64'(timeout), 64'(t));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got expired, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // ---------------- reset ----------------
        step(2);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        step(1);

        // ---------------- 1: pass run ----------------
        start = 1'b1; step(1); start = 1'b0;
        check_flags("t1_run", 1'b1, 1'b0, 1'b0, 1'b0);
        evt = 4'b0010; step(10);            // 10 RUN cycles with evt[1]
        evt = 4'b0000; step(40);            // 40 more
        st_valid = 1'b1; st_addr = TOHOST; st_data = 32'h1;
        step(1);
        st_valid = 1'b0;
        check_flags("t1_done", 1'b0, 1'b1, 1'b1, 1'b0);
        rd_main("t1_cyc", 3'd0, 64'd51);
        rd_main("t1_evt0", 3'd1, 64'd0);
        rd_main("t1_evt1", 3'd2, 64'd10);
        rd_main("t1_status", 3'd5, 64'd6);   // DONE=2 | pass<<2
        rd_main("t1_oor6", 3'd6, 64'd0);
        rd_main("t1_oor7", 3'd7, 64'd0);
        step(1);
        check("t1_rd_valid_drop", 64'(rd_valid), 64'd0);
        stop = 1'b1; step(1); stop = 1'b0;
        check_flags("t1_stop_ignored", 1'b0, 1'b1, 1'b1, 1'b0);

        // ---------------- 2: watchdog ----------------
        start = 1'b1; step(1); start = 1'b0;
        check_flags("t2_start_clears", 1'b1, 1'b0, 1'b0, 1'b0);
        st_valid = 1'b1; st_addr = 32'h0000_2000; st_data = 32'h1;
        step(1);                             // RUN cycle 1, non-tohost store
        st_valid = 1'b0;
        check_flags("t2_nontohost", 1'b1, 1'b0, 1'b0, 1'b0);
        step(TMO - 2);                       // through RUN cycle TMO-1
        check_flags("t2_pre_tmo", 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);                             // RUN cycle TMO
        check_flags("t2_tmo", 1'b0, 1'b0, 1'b0, 1'b1);
        rd_main("t2_cyc", 3'd0, 64'(TMO));
        rd_main("t2_status", 3'd5, 64'd3);
        stop = 1'b1; step(1); stop = 1'b0;
        check_flags("t2_stop_ignored", 1'b0, 1'b0, 1'b0, 1'b1);

        // ---------------- 3: tohost vs timeout ----------------
        start = 1'b1; step(1); start = 1'b0;
        step(TMO - 1);
        st_valid = 1'b1; st_addr = TOHOST; st_data = 32'h3;
        step(1);
        st_valid = 1'b0;
        check_flags("t3_done_wins", 1'b0, 1'b1, 1'b0, 1'b0);
        rd_main("t3_cyc", 3'd0, 64'(TMO));

        // ---------------- 4: saturation (8-bit instance) ----------------
        s_start = 1'b1; step(1); s_start = 1'b0;
        check("t4_running", 64'(s_running), 64'd1);
        s_evt = 4'b0001;
        step(299);
        s_stop = 1'b1;                       // 300th RUN cycle is the exit cycle
        step(1);
        s_stop = 1'b0; s_evt = 4'b0000;
        check("t4_idle", 64'(s_running), 64'd0);
        check("t4_not_done", 64'(s_done | s_timeout | s_pass), 64'd0);
        rd_sat("t4_evt0", 3'd1, 64'd255);
        rd_sat("t4_cyc", 3'd0, 64'd255);
        rd_sat("t4_evt1", 3'd2, 64'd0);
        rd_sat("t4_status", 3'd5, 64'd24);   // IDLE, ovf bits 0 and 1
        step(5);
        rd_sat("t4_evt0_hold", 3'd1, 64'd255);

        // ---------------- 5: reset mid-RUN, restart ----------------
        start = 1'b1; step(1); start = 1'b0;
        step(20);
        rst_n = 1'b0; step(1);
        check_flags("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_rd_valid", 64'(rd_valid), 64'd0);
        check("t5_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        rd_main("t5_cyc_cleared", 3'd0, 64'd0);
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        rd_main("t5_pre_inc", 3'd0, 64'd3);  // sampled before the 4th increment
        stop = 1'b1; step(1); stop = 1'b0;
        check_flags("t5_stopped", 1'b0, 1'b0, 1'b0, 1'b0);
        rd_main("t5_cyc_hold", 3'd0, 64'd5);

`ifdef PERF_RUN_MONITOR_SNAPSHOT_EN
        // ---------------- 6: snapshot ----------------
        start = 1'b1; step(1); start = 1'b0;
        step(20);
        snap = 1'b1; step(1); snap = 1'b0;
        step(10);
        rd_main("t6_shadow", 3'd0, 64'd20);
        rd_en = 1'b1; rd_idx = 3'd5; step(1); rd_en = 1'b0;
        check("t6_status_run", 64'(rd_data[1:0]), 64'd1);
        snap = 1'b1; rd_en = 1'b1; rd_idx = 3'd0; step(1);
        snap = 1'b0; rd_en = 1'b0;
        check("t6_snap_rd_old", 64'(rd_data), 64'd20);
        rd_main("t6_snap_new", 3'd0, 64'd33);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
